priority_arbiter: RTL and testbench

Shares one resource among 7 requesters, indexed 1..7. Higher index wins in fixed mode, matching the lab priority encoder convention. Optional round-robin rotation and a maximum-hold timeout prevent starvation. Grant is registered: a one-hot vector plus an encoded 3-bit id. Id 0 means no grant.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/priority_arbiter_rr_pick.sv | 34 +++
 rtl/priority_arbiter.sv | 116 +++++++++++
 tb/tb_priority_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and helpers for the 7-requester priority arbiter.
// Requesters are indexed 1..NREQ; index 0 is reserved to mean "no grant".
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NREQ = 7;
  localparam int IDW  = 3;
  localparam logic [IDW-1:0] NOGRANT = 3'd0;

  // Highest set index of v, or NOGRANT when v is empty.
  function automatic logic [IDW-1:0] highestIdx(input logic [NREQ:1] v);
    logic [IDW-1:0] idx;
    idx = NOGRANT;
    for (int i = 1; i <= NREQ; i++) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_arbiter_rr_pick.sv
// Combinational winner selection: fixed highest-index priority, or a rotating
// search that starts just below the previous winner and wraps back to 7.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ:1]  eff,
  input  logic [IDW-1:0] last,
  input  logic           rr,
  output logic [IDW-1:0] w
);

  logic [NREQ:1]  w_below;
  logic [NREQ:1]  w_atOrAbove;
  logic [IDW-1:0] w_belowIdx;
  logic [IDW-1:0] w_aboveIdx;
  logic [IDW-1:0] w_fixedIdx;

  // Split requests at the previous winner: indices below it are searched first.
  always_comb begin
    w_below     = '0;
    w_atOrAbove = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (IDW'(i) < last) w_below[i] = eff[i];
      else                w_atOrAbove[i] = eff[i];
    end
  end

  assign w_belowIdx = highestIdx(w_below);
  assign w_aboveIdx = highestIdx(w_atOrAbove);
  assign w_fixedIdx = highestIdx(eff);

  assign w = !rr ? w_fixedIdx : ((|w_below) ? w_belowIdx : w_aboveIdx);

endmodule

// File: rtl/priority_arbiter.sv
// Registered 7-way arbiter with optional round-robin rotation and a contended
// hold limit; a revoked owner sits out exactly one following arbitration.
module priority_arbiter
  import arb_pkg::*;
#(
  parameter int RR      = 1,
  parameter int MAXHOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NREQ:1]  req,
  output logic [NREQ:1]  gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  localparam int CW = (MAXHOLD < 1) ? 1 : $clog2(MAXHOLD + 1);
  localparam logic HOLD_EN = (MAXHOLD != 0);
  localparam logic RR_EN   = (RR != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);

  state_t         r_state, w_nextState;
  logic [NREQ:1]  r_gnt, w_nextGnt;
  logic [IDW-1:0] r_gntId, w_nextGntId;
  logic           r_timeout, w_nextTimeout;
  logic [CW-1:0]  r_cnt, w_nextCnt;
  logic [IDW-1:0] r_last, w_nextLast;
  logic [NREQ:1]  r_mask, w_nextMask;

  logic [NREQ:1]  w_eff;
  logic [IDW-1:0] w_win;
  logic           w_ownerReq;
  logic           w_othersWaiting;
  logic           w_holdLimit;

  assign w_eff           = req & ~r_mask;
  assign w_ownerReq      = |(req & r_gnt);
  assign w_othersWaiting = |(req & ~r_gnt);
  assign w_holdLimit     = HOLD_EN && (r_cnt == HOLD_LAST);

  rr_pick u_rrPick (
    .eff  (w_eff),
    .last (r_last),
    .rr   (RR_EN),
    .w    (w_win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gntId   <= NOGRANT;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_last    <= IDW'(NREQ);
      r_mask    <= '0;
    end else begin
      r_state   <= w_nextState;
      r_gnt     <= w_nextGnt;
      r_gntId   <= w_nextGntId;
      r_timeout <= w_nextTimeout;
      r_cnt     <= w_nextCnt;
      r_last    <= w_nextLast;
      r_mask    <= w_nextMask;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextGnt     = r_gnt;
    w_nextGntId   = r_gntId;
    w_nextTimeout = 1'b0;
    w_nextCnt     = r_cnt;
    w_nextLast    = r_last;
    w_nextMask    = r_mask;
    case (r_state)
      IDLE: begin
        w_nextMask = '0;
        if (|w_eff) begin
          w_nextGnt        = '0;
          w_nextGnt[w_win] = 1'b1;
          w_nextGntId      = w_win;
          w_nextCnt        = '0;
          w_nextLast       = w_win;
          w_nextState      = BUSY;
        end
      end
      BUSY: begin
        if (!w_ownerReq) begin
          w_nextGnt   = '0;
          w_nextGntId = NOGRANT;
          w_nextState = IDLE;
        end else if (w_othersWaiting && w_holdLimit) begin
          // Mask the revoked owner so the waiting requester actually gets in.
          w_nextGnt     = '0;
          w_nextGntId   = NOGRANT;
          w_nextState   = IDLE;
          w_nextTimeout = 1'b1;
          w_nextMask    = r_gnt;
        end else if (w_othersWaiting && HOLD_EN) begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gntId;
  assign busy    = (r_state == BUSY);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench: a fixed-priority and a round-robin arbiter run side by
// side against a transaction-level model of owner, hold time and rotation.
module tb_priority_arbiter;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:1] reqF, reqR;
  logic [7:1] gntF, gntR;
  logic [2:0] idF, idR;
  logic       busyF, busyR, toF, toR;

  int errors = 0;
  int checks = 0;

  int mRr[2];
  int mHold[2];
  int mOwner[2];
  int mHeld[2];
  int mLast[2];
  int mExcl[2];
  bit mTo[2];

  always #5 clk = ~clk;

  priority_arbiter #(.RR(0), .MAXHOLD(8)) dutFixed (
    .clk(clk), .reset(reset), .req(reqF),
    .gnt(gntF), .gnt_id(idF), .busy(busyF), .timeout(toF)
  );

  priority_arbiter #(.RR(1), .MAXHOLD(4)) dutRr (
    .clk(clk), .reset(reset), .req(reqR),
    .gnt(gntR), .gnt_id(idR), .busy(busyR), .timeout(toR)
  );

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mOwner[d] = 0;
      mHeld[d]  = 0;
      mLast[d]  = 7;
      mExcl[d]  = 0;
      mTo[d]    = 1'b0;
    end
  endtask

  // Fixed: scan 7..1. Rotating: scan last-1, last-2, ... wrapping 1 -> 7.
  function automatic int pickWinner(int d, logic [7:1] eff);
    int c;
    if (mRr[d] == 0) begin
      for (int k = 7; k >= 1; k--) if (eff[k]) return k;
    end else begin
      for (int k = 1; k <= 7; k++) begin
        c = mLast[d] - k;
        if (c < 1) c += 7;
        if (eff[c]) return c;
      end
    end
    return 0;
  endfunction

  task automatic modelEdge(int d, logic [7:1] r);
    logic [7:1] eff;
    int w;
    bit others;
    mTo[d] = 1'b0;
    if (mOwner[d] == 0) begin
      eff = r;
      if (mExcl[d] != 0) eff[mExcl[d]] = 1'b0;
      mExcl[d] = 0;
      w = pickWinner(d, eff);
      if (w != 0) begin
        mOwner[d] = w;
        mHeld[d]  = 0;
        mLast[d]  = w;
      end
    end else if (!r[mOwner[d]]) begin
      mOwner[d] = 0;
    end else begin
      others = 1'b0;
      for (int c = 1; c <= 7; c++) if (c != mOwner[d] && r[c]) others = 1'b1;
      if (others) begin
        if (mHold[d] != 0 && mHeld[d] + 1 == mHold[d]) begin
          mExcl[d]  = mOwner[d];
          mOwner[d] = 0;
          mTo[d]    = 1'b1;
        end else begin
          mHeld[d]++;
        end
      end
    end
  endtask

  function automatic logic [7:0] expGnt(int d);
    logic [7:0] g;
    g = '0;
    if (mOwner[d] != 0) g[mOwner[d] - 1] = 1'b1;
    return g;
  endfunction

  task automatic checkVal(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("fixed_gnt",     {1'b0, gntF},  expGnt(0));
    checkVal("fixed_id",      {5'b0, idF},   8'(mOwner[0]));
    checkVal("fixed_busy",    {7'b0, busyF}, 8'(mOwner[0] != 0));
    checkVal("fixed_timeout", {7'b0, toF},   {7'b0, mTo[0]});
    checkVal("rr_gnt",        {1'b0, gntR},  expGnt(1));
    checkVal("rr_id",         {5'b0, idR},   8'(mOwner[1]));
    checkVal("rr_busy",       {7'b0, busyR}, 8'(mOwner[1] != 0));
    checkVal("rr_timeout",    {7'b0, toR},   {7'b0, mTo[1]});
  endtask

  // Drive at the falling edge, let one rising edge sample, check at the next fall.
  task automatic applyStimulus(logic [7:1] rF, logic [7:1] rR);
    reqF = rF;
    reqR = rR;
    @(posedge clk);
    modelEdge(0, reqF);
    modelEdge(1, reqR);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyReset();
    reset = 1'b1;
    reqF  = '0;
    reqR  = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:1] v;
    logic [7:1] rf;
    logic [7:1] rr;
    int seq[8];
    mRr   = '{0, 1};
    mHold = '{8, 4};
    seq   = '{6, 5, 4, 3, 2, 1, 7, 6};
    reset = 1'b1;
    reqF  = '0;
    reqR  = '0;

    $display("[TB] zero requests after reset");
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus('0, '0);
    checkVal("idle_gnt", {1'b0, gntR}, 8'h00);

    $display("[TB] fixed priority");
    applyReset();
    applyStimulus(7'b0010110, '0);
    checkVal("t1_first_id", {5'b0, idF}, 8'd5);
    checkVal("t1_first_gnt", {1'b0, gntF}, 8'b0010000);
    applyStimulus(7'b0000110, '0);
    checkVal("t1_turnaround", {1'b0, gntF}, 8'h00);
    applyStimulus(7'b0000110, '0);
    checkVal("t1_next_id", {5'b0, idF}, 8'd3);

    $display("[TB] round-robin rotation");
    applyReset();
    foreach (seq[g]) begin
      applyStimulus('0, 7'h7F);
      checkVal("t2_grant", {5'b0, idR}, 8'(seq[g]));
      applyStimulus('0, 7'h7F);
      v = 7'h7F;
      v[seq[g]] = 1'b0;
      applyStimulus('0, v);
      checkVal("t2_gap", {1'b0, gntR}, 8'h00);
    end

    $display("[TB] hold timeout");
    applyReset();
    applyStimulus('0, 7'b0000010);
    checkVal("t3_owner2", {5'b0, idR}, 8'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, 7'b0100010);
      checkVal("t3_held", {5'b0, idR}, 8'd2);
    end
    applyStimulus('0, 7'b0100010);
    checkVal("t3_pulse", {7'b0, toR}, 8'd1);
    checkVal("t3_revoked", {1'b0, gntR}, 8'h00);
    applyStimulus('0, 7'b0100010);
    checkVal("t3_owner6", {5'b0, idR}, 8'd6);
    checkVal("t3_pulse_end", {7'b0, toR}, 8'd0);
    applyStimulus('0, 7'b0100010);
    applyStimulus('0, 7'b0000010);
    applyStimulus('0, 7'b0000010);
    checkVal("t3_regrant2", {5'b0, idR}, 8'd2);

    $display("[TB] uncontended hold");
    applyReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus('0, 7'b0001000);
      checkVal("t4_id", {5'b0, idR}, 8'd4);
      checkVal("t4_no_timeout", {7'b0, toR}, 8'd0);
    end

    $display("[TB] async reset mid-grant");
    applyReset();
    applyStimulus('0, 7'b0000100);
    checkVal("t5_owner3", {5'b0, idR}, 8'd3);
    #2;
    reset = 1'b1;
    #1;
    checkVal("t5_async_gnt", {1'b0, gntR}, 8'h00);
    checkVal("t5_async_id", {5'b0, idR}, 8'h00);
    checkVal("t5_async_busy", {7'b0, busyR}, 8'h00);
    reqR = 7'h7F;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus('0, 7'h7F);
    checkVal("t5_first_after", {5'b0, idR}, 8'd6);

    $display("[TB] randomized traffic");
    applyReset();
    rf = '0;
    rr = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 1; b <= 7; b++) begin
        if ($urandom_range(3) == 0) rf[b] = ~rf[b];
        if ($urandom_range(3) == 0) rr[b] = ~rr[b];
      end
      applyStimulus(rf, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
